mem_model_dp: RTL and testbench

//  Parametrised dual-port word-addressed memory model for the RV32I core and testbenches.

---
 rtl/mem_model_dp_if.sv | 33 +++
 rtl/mem_model_dp.sv | 122 ++++++++++++
 tb/tb_mem_model_dp.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_model_dp_if.sv
// Bus interface for mem_model_dp: port A read-only fetch and port B byte-strobed read/write.
// The memory takes the slave modport; a requester or bench takes the master modport.
interface mem_model_dp_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH;

  logic                  a_req;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvld;
  logic                  a_err;

  logic                  b_req;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic [STRB_WIDTH-1:0] b_wen;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_rvld;
  logic                  b_err;

  modport master (
    output a_req, a_addr, b_req, b_addr, b_wdata, b_wen,
    input  a_rdata, a_rvld, a_err, b_rdata, b_rvld, b_err
  );

  modport slave (
    input  a_req, a_addr, b_req, b_addr, b_wdata, b_wen,
    output a_rdata, a_rvld, a_err, b_rdata, b_rvld, b_err
  );
endinterface

// File: rtl/mem_model_dp.sv
// Dual-port word memory: port A read-only, port B byte-strobed read/write, RD_LAT-cycle read pipes.
// Build option MEM_COLLISION_FWD_EN: port A sees port B's same-cycle write (write-first) instead of old data.
module mem_model_dp #(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1,
  localparam int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH
) (
  input logic           CLK,
  input logic           RSTN,
  mem_model_dp_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  logic                  w_a_in;
  logic                  w_b_in;
  logic                  w_b_wr;
  logic                  w_b_rd;
  logic [DATA_WIDTH-1:0] w_a_word;
  logic [DATA_WIDTH-1:0] w_b_word;

  logic [RD_LAT-1:0]     r_a_vld;
  logic [RD_LAT-1:0]     r_a_err;
  logic [DATA_WIDTH-1:0] r_a_dat [RD_LAT];
  logic [RD_LAT-1:0]     r_b_vld;
  logic [RD_LAT-1:0]     r_b_err;
  logic [DATA_WIDTH-1:0] r_b_dat [RD_LAT];
  logic                  r_b_werr;

  assign w_a_in = {1'b0, bus.a_addr} < DEPTH_W;
  assign w_b_in = {1'b0, bus.b_addr} < DEPTH_W;
  assign w_b_wr = bus.b_req && (|bus.b_wen);
  assign w_b_rd = bus.b_req && !(|bus.b_wen);

  // NOTE: always_comb outputs get a default assignment first so no path can infer a latch.
  always_comb begin
    w_a_word = '0;
    if (w_a_in) begin
      w_a_word = r_mem[bus.a_addr];
`ifdef MEM_COLLISION_FWD_EN
      if (w_b_wr && w_b_in && (bus.a_addr == bus.b_addr)) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
          if (bus.b_wen[i]) w_a_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
`endif
    end
  end

  always_comb begin
    w_b_word = '0;
    if (w_b_in) w_b_word = r_mem[bus.b_addr];
  end

  // NOTE: the array is deliberately not reset; its contents survive RSTN, only the read pipes clear.
  always_ff @(posedge CLK) begin
    if (RSTN && w_b_wr && w_b_in) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (bus.b_wen[i]) r_mem[bus.b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // NOTE: all state updates are non-blocking so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_a_vld <= '0;
      r_a_err <= '0;
      for (int k = 0; k < RD_LAT; k++) r_a_dat[k] <= '0;
    end else begin
      r_a_vld[0] <= bus.a_req;
      if (bus.a_req) begin
        r_a_dat[0] <= w_a_word;
        r_a_err[0] <= !w_a_in;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        r_a_vld[k] <= r_a_vld[k-1];
        if (r_a_vld[k-1]) begin
          r_a_dat[k] <= r_a_dat[k-1];
          r_a_err[k] <= r_a_err[k-1];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_b_vld  <= '0;
      r_b_err  <= '0;
      r_b_werr <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) r_b_dat[k] <= '0;
    end else begin
      r_b_werr   <= w_b_wr && !w_b_in;
      r_b_vld[0] <= w_b_rd;
      if (w_b_rd) begin
        r_b_dat[0] <= w_b_word;
        r_b_err[0] <= !w_b_in;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        r_b_vld[k] <= r_b_vld[k-1];
        if (r_b_vld[k-1]) begin
          r_b_dat[k] <= r_b_dat[k-1];
          r_b_err[k] <= r_b_err[k-1];
        end
      end
    end
  end

  // Stage data only advances with a valid entry, so the outputs hold between responses.
  assign bus.a_rdata = r_a_dat[RD_LAT-1];
  assign bus.a_rvld  = r_a_vld[RD_LAT-1];
  assign bus.a_err   = r_a_vld[RD_LAT-1] && r_a_err[RD_LAT-1];
  assign bus.b_rdata = r_b_dat[RD_LAT-1];
  assign bus.b_rvld  = r_b_vld[RD_LAT-1];
  assign bus.b_err   = (r_b_vld[RD_LAT-1] && r_b_err[RD_LAT-1]) || r_b_werr;

endmodule

// File: tb/tb_mem_model_dp.sv
// Self-checking bench for mem_model_dp: directed scenarios plus random traffic against an array/queue model.
module tb_mem_model_dp;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int SW    = DW / BW;
  localparam int DEPTH = 1000;
  localparam int LAT   = 3;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  mem_model_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

  mem_model_dp #(
    .BYTE_WIDTH(BW), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LAT(LAT)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus.slave)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            due;
  } rsp_t;

  rsp_t          qa[$];
  rsp_t          qb[$];
  logic [DW-1:0] model [DEPTH];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            b_werr_due = -1;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  logic [DW-1:0] obs_a  = '0;
  logic [DW-1:0] obs_b  = '0;
  logic          obs_a_err = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Expected response for each port is whatever the queue head says is due this cycle.
  task automatic monitor();
    logic ea, eb, ee;
    ea = (qa.size() > 0) && (qa[0].due == cyc);
    check("a_rvld", 32'(bus.a_rvld), 32'(ea));
    if (ea) begin
      check("a_rdata", bus.a_rdata, qa[0].d);
      check("a_err", 32'(bus.a_err), 32'(qa[0].e));
      last_a    = qa[0].d;
      obs_a     = bus.a_rdata;
      obs_a_err = bus.a_err;
      void'(qa.pop_front());
    end else begin
      check("a_hold", bus.a_rdata, last_a);
      check("a_err_idle", 32'(bus.a_err), 32'd0);
    end
    eb = (qb.size() > 0) && (qb[0].due == cyc);
    ee = (eb && qb[0].e) || (b_werr_due == cyc);
    check("b_rvld", 32'(bus.b_rvld), 32'(eb));
    check("b_err", 32'(bus.b_err), 32'(ee));
    if (eb) begin
      check("b_rdata", bus.b_rdata, qb[0].d);
      last_b = qb[0].d;
      obs_b  = bus.b_rdata;
      void'(qb.pop_front());
    end else begin
      check("b_hold", bus.b_rdata, last_b);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    monitor();
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    bus.b_wen = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 1; i++) tick();
  endtask

  // Drive one cycle's requests and update the model with the memory's rules.
  task automatic issue(input logic ar, input int aa, input logic br, input int ba,
                       input logic [DW-1:0] bd, input logic [SW-1:0] bw);
    logic [DW-1:0] exp;
    logic          a_in, b_in, bwr;
    bus.a_req   = ar;
    bus.a_addr  = AW'(aa);
    bus.b_req   = br;
    bus.b_addr  = AW'(ba);
    bus.b_wdata = bd;
    bus.b_wen   = bw;
    if (RSTN) begin
      a_in = aa < DEPTH;
      b_in = ba < DEPTH;
      bwr  = br && (bw != '0);
      if (ar) begin
        exp = a_in ? model[aa] : '0;
`ifdef MEM_COLLISION_FWD_EN
        if (a_in && bwr && b_in && aa == ba)
          for (int i = 0; i < SW; i++) if (bw[i]) exp[i*BW +: BW] = bd[i*BW +: BW];
`endif
        qa.push_back('{d: exp, e: !a_in, due: cyc + LAT});
      end
      if (br && !bwr) qb.push_back('{d: (b_in ? model[ba] : '0), e: !b_in, due: cyc + LAT});
      if (bwr) begin
        if (b_in) begin
          for (int i = 0; i < SW; i++) if (bw[i]) model[ba][i*BW +: BW] = bd[i*BW +: BW];
        end else begin
          b_werr_due = cyc + 1;
        end
      end
    end
  endtask

  initial begin
    int aa, ba;
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_wen = '0;

    // Reset state: monitor expects no rvld and zero data/err.
    for (int i = 0; i < 3; i++) tick();
    #2 RSTN = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, 0, 1'b1, i, DW'($urandom), '1);
      tick();
    end

    // Write then fetch the same word on the next cycle.
    issue(1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 4'hF); tick();
    issue(1'b1, 5, 1'b0, 0, '0, '0); tick();
    drain();
    check("t1_data", obs_a, 32'hDEADBEEF);

    // Single-lane partial write followed by a B read.
    issue(1'b0, 0, 1'b1, 3, 32'h11223344, 4'hF); tick();
    issue(1'b0, 0, 1'b1, 3, 32'h0000AA00, 4'b0010); tick();
    issue(1'b0, 0, 1'b1, 3, '0, '0); tick();
    drain();
    check("t2_data", obs_b, 32'h1122AA44);

    // Same-cycle A read and B write to word 7.
    issue(1'b0, 0, 1'b1, 7, 32'h0, 4'hF); tick();
    issue(1'b1, 7, 1'b1, 7, 32'hFFFFFFFF, 4'hF); tick();
    issue(1'b0, 0, 1'b1, 7, '0, '0); tick();
    drain();
`ifdef MEM_COLLISION_FWD_EN
    check("t3_a_coll", obs_a, 32'hFFFFFFFF);
`else
    check("t3_a_coll", obs_a, 32'h00000000);
`endif
    check("t3_b_after", obs_b, 32'hFFFFFFFF);

    // Back-to-back fetch burst; monitor checks contiguous in-order rvld.
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 0, 1'b1, i, DW'(i) * 32'h11111111, 4'hF); tick();
    end
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, i, 1'b0, 0, '0, '0); tick();
    end
    drain();
    check("t4_last", obs_a, 32'h77777777);

    // Out-of-range read and write.
    issue(1'b1, DEPTH, 1'b0, 0, '0, '0); tick();
    drain();
    check("t5_a_data", obs_a, 32'h0);
    check("t5_a_err", 32'(obs_a_err), 32'd1);
    issue(1'b0, 0, 1'b1, 1010, 32'hFFFFFFFF, 4'hF); tick();
    drain();

    // Reset with two reads in flight; requests during reset must be ignored.
    issue(1'b1, 20, 1'b0, 0, '0, '0); tick();
    issue(1'b0, 0, 1'b1, 21, '0, '0); tick();
    RSTN = 1'b0;
    #1;
    check("rst_a_rvld", 32'(bus.a_rvld), 32'd0);
    check("rst_a_rdata", bus.a_rdata, 32'd0);
    check("rst_a_err", 32'(bus.a_err), 32'd0);
    check("rst_b_rvld", 32'(bus.b_rvld), 32'd0);
    check("rst_b_rdata", bus.b_rdata, 32'd0);
    check("rst_b_err", 32'(bus.b_err), 32'd0);
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0; b_werr_due = -1;
    tick();
    issue(1'b1, 20, 1'b1, 20, 32'hA5A5A5A5, 4'hF); tick();
    tick();
    #2 RSTN = 1'b1;
    for (int i = 0; i < LAT + 3; i++) tick();
    issue(1'b1, 20, 1'b0, 0, '0, '0); tick();
    issue(1'b0, 0, 1'b1, 21, '0, '0); tick();
    drain();
    check("t6_a_reread", obs_a, model[20]);
    check("t6_b_reread", obs_b, model[21]);

    // Random mixed traffic with occasional out-of-range addresses and forced collisions.
    for (int n = 0; n < 3000; n++) begin
      aa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 1023)) : int'($urandom_range(0, DEPTH - 1));
      ba = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 1023)) : int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) ba = aa;
      issue(1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), ba,
            DW'($urandom), SW'($urandom_range(0, (1 << SW) - 1)));
      tick();
    end

    // Full-space sweep on both ports: confirms out-of-range writes touched nothing.
    for (int i = 0; i < (1 << AW); i++) begin
      issue(1'b1, i, 1'b1, (1 << AW) - 1 - i, '0, '0);
      tick();
    end
    drain();
    check("q_a_empty", 32'(qa.size()), 32'd0);
    check("q_b_empty", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
